// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer. in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to the upstream stage. The stage also has a synchronous
// flush and a saturating counter of downstream stall cycles.
module pipe_stage_skid #(
    parameter int unsigned          DATA_W    = 32,
    parameter logic [DATA_W-1:0]    FLUSH_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main entry drives the outputs. The skid entry catches the word that was
    // accepted while the main entry was blocked.
    logic              m_v;
    logic              s_v;
    logic [DATA_W-1:0] m_d;
    logic [DATA_W-1:0] s_d;
    logic              push;
    logic              pop;

    assign in_ready  = !s_v;
    assign out_valid = m_v;
    assign out_data  = m_d;
    assign occupancy = {1'b0, m_v} + {1'b0, s_v};
    assign push      = in_valid && in_ready;
    assign pop       = m_v && out_ready;

    // Entry storage: reset beats flush, flush beats handshake. Data registers
    // are written only on push, pop, flush or reset.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= FLUSH_VAL;
            s_d <= FLUSH_VAL;
        end else if (!m_v) begin
            // EMPTY
            if (push) begin
                m_v <= 1'b1;
                m_d <= in_data;
            end
        end else if (!s_v) begin
            // ONE
            if (push && pop) begin
                m_d <= in_data;
            end else if (push) begin
                s_v <= 1'b1;
                s_d <= in_data;
            end else if (pop) begin
                m_v <= 1'b0;
            end
        end else begin
            // TWO: in_ready is low, so only a pop can move the state
            if (pop) begin
                m_d <= s_d;
                s_v <= 1'b0;
            end
        end
    end

    // Stall counter: counts cycles where valid output is held back. It
    // saturates at all-ones, and a flush does not clear it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!flush && m_v && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. A queue model runs at every negedge
// and checks the outputs against it. Directed phases cover reset, streaming,
// backpressure and flush. A second instance with a narrow counter covers
// saturation. A long random phase runs at the end.
module tb_pipe_stage_skid;

    localparam int unsigned      DW    = 32;
    localparam logic [DW-1:0]    FV2   = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          in_valid2;
    logic          in_ready2;
    logic [DW-1:0] in_data2;
    logic          out_valid2;
    logic          out_ready2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occupancy2;
    logic [3:0]    stall_cnt2;

    int unsigned   errors = 0;
    int unsigned   checks = 0;

    logic [DW-1:0] exp_q[$];
    logic [15:0]   exp_stall;
    logic          bubble;
    logic          armed;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_skid #(
        .DATA_W    (DW),
        .FLUSH_VAL (FV2),
        .CNT_W     (4)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .occupancy (occupancy2),
        .stall_cnt (stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model. Inputs are stable at the negedge, so the model first
    // checks the present state and then applies this cycle's handshake.
    always @(negedge clk) begin
        int unsigned sz;
        logic        do_pop;
        logic        do_push;
        sz = exp_q.size();
        if (armed) begin
            check("occupancy", 64'(occupancy), 64'(sz));
            check("out_valid", 64'(out_valid), 64'(sz > 0));
            check("in_ready", 64'(in_ready), 64'(sz < 2));
            check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            if (sz > 0)
                check("out_data", 64'(out_data), 64'(exp_q[0]));
            else if (bubble)
                check("bubble_data", 64'(out_data), 64'(0));
        end
        if (!rst) begin
            exp_q.delete();
            exp_stall = '0;
            bubble    = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            bubble = 1'b1;
        end else begin
            do_pop  = (sz > 0) && out_ready;
            do_push = in_valid && (sz < 2);
            if (sz > 0 && !out_ready && exp_stall != 16'hFFFF)
                exp_stall = exp_stall + 16'd1;
            if (do_pop)
                void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(in_data);
                bubble = 1'b0;
            end
        end
    end

    initial begin
        armed      = 1'b0;
        exp_stall  = '0;
        bubble     = 1'b1;
        rst        = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;

        // Reset while upstream offers data
        tick();
        tick();
        armed = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_sat_data", 64'(out_data2), 64'(FV2));
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd10;
        tick();
        in_data = 32'd11;
        tick();
        in_data = 32'd12;
        tick();
        in_valid = 1'b0;
        tick();
        check("bp_occupancy", 64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_stall", 64'(stall_cnt), 64'd3);
        check("bp_head", 64'(out_data), 64'd10);
        out_ready = 1'b1;
        tick();
        check("bp_second", 64'(out_data), 64'd11);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush in TWO, with a word offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd20;
        tick();
        in_data = 32'd21;
        tick();
        check("fl_full", 64'(occupancy), 64'd2);
        in_data = 32'd99;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occupancy", 64'(occupancy), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_data", 64'(out_data), 64'd0);
        check("fl_stall_kept", 64'(stall_cnt), 64'd4);
        tick();
        check("fl_no_99", 64'(out_valid), 64'd0);

        // Narrow counter saturates
        in_valid2 = 1'b1;
        in_data2  = 32'd77;
        tick();
        in_valid2 = 1'b0;
        repeat (10) tick();
        check("sat_mid", 64'(stall_cnt2), 64'd10);
        repeat (11) tick();
        check("sat_top", 64'(stall_cnt2), 64'd15);
        check("sat_data", 64'(out_data2), 64'd77);
        check("sat_occ", 64'(occupancy2), 64'd1);

        // Random valid/ready with occasional flush and reset
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
